dac_wave_gen: RTL and testbench
===============================

// Module: dac_wave_gen
// PURPOSE
//  Parametrised waveform sequencer for an I2C DAC. Generates hold/saw/triangle/square codes
//  on a programmable tick and launches one 2-byte write per sample through iic_drive
//  (ADDR_BYTE_NUM=0, DATA_BYTE_NUM=2). Reports overrun and ACK errors. Supersedes the fixed breathing ramp.
// PARAMETERS
//  TICK_DIV  1_000_000  dac_clk cycles per sample tick (>=2)
//  DATA_W    8          DAC code width: 8, 10 or 12
//  PD_BITS   2'b00      power-down bits placed in payload [13:12]
// PORTS
//  dac_clk        in   1       system clock
//  dac_rst_n      in   1       async active-low reset
//  run            in   1       1: generate/send; 0: stop after the current transfer
//  cfg_mode       in   2       0 HOLD, 1 SAW, 2 TRIANGLE, 3 SQUARE
//  cfg_min        in   DATA_W  lower bound
//  cfg_max        in   DATA_W  upper bound
//  cfg_step       in   DATA_W  increment per tick (0 = frozen)
//  cfg_level      in   DATA_W  HOLD value
//  stat_clr       in   1       1-cycle pulse: clear overrun, ack_err
//  iic_ready      in   1       from iic_drive: 1 idle
//  iic_ack_error  in   1       from iic_drive: ACK failure pulse/level
//  iic_start      out  1       1-cycle launch pulse to iic_drive
//  iic_wdata      out  16      {hi byte, lo byte}, hi byte sent first
//  cur_code       out  DATA_W  code currently generated
//  busy           out  1       transfer in flight
//  overrun        out  1       sticky: a tick was lost while a transfer was pending
//  ack_err        out  1       sticky: iic_ack_error was seen
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, tick counter 0, dir=up, pending=0.
//  Payload: code12 = cur_code << (12-DATA_W); iic_wdata = {2'b00, PD_BITS, code12}.
//   DATA_W=8, PD=0 -> {4'h0,c[7:4]},{c[3:0],4'h0}. iic_wdata holds constant from start until the transfer completes.
//  Run rise: tick counter=0, dir=up, cur_code=cfg_level (HOLD), cfg_min (SAW/TRI/SQR),
//   then an immediate launch (no wait for the first tick).
//  Tick: tick counter counts 0..TICK_DIV-1 while run=1. Tick is asserted at TICK_DIV-1,
//   and cur_code advances on that cycle. cfg_* are sampled on that tick.
//  Arithmetic in DATA_W+1 bits, nxt = cur+step:
//   HOLD: cur=cfg_level.
//   SAW: nxt>max -> min, else nxt.
//   TRI up: nxt>=max -> max, dir=down. TRI down: cur<min+step -> min, dir=up; else cur-step.
//   SQR: cur==min -> max, else min.
//   cfg_min>cfg_max in SAW/TRI/SQR: cur=cfg_min (degenerate hold). Mode change applies at the next tick without restart.
//  FSM states:
//   IDLE: entered when run=0.
//   WAIT_TICK: on tick, or pending set -> LAUNCH.
//   LAUNCH: waits for iic_ready=1, then drives iic_start=1 for exactly one cycle and latches iic_wdata -> WAIT_LO.
//   WAIT_LO: waits for iic_ready=0 -> WAIT_HI.
//   WAIT_HI: waits for iic_ready=1, clears pending -> WAIT_TICK if run=1, else IDLE.
//  Pending/overrun:
//   Tick while in LAUNCH/WAIT_LO/WAIT_HI -> pending=1, and the next launch sends the latest cur_code.
//   Tick while pending is already 1 -> overrun=1. The waveform never stalls.
//  busy=1 in LAUNCH/WAIT_LO/WAIT_HI.
//  ack_err set on any cycle with iic_ack_error=1. The transfer is not retried.
//  stat_clr clears overrun and ack_err. A simultaneous set wins.
//  run=0 mid-transfer: no abort; finish WAIT_HI, then IDLE with cur_code held.
//  run re-rise restarts from the start value.
//  Async reset mid-transfer: immediate return to reset values.
//   iic_start is 0 during and after reset until run=1.
// TESTING
//  T1 DATA_W=8, HOLD, level=8'hA5, run=1 -> one iic_start within 2 clk, iic_wdata=16'h0A50.
//  T2 SAW, min=8'h70, max=8'h73, step=1, TICK_DIV=8 -> cur_code 70,71,72,73,70 every 8 clk, one start per tick.
//  T3 TRI, min=2, max=9, step=4 -> 2,6,9,5,2,6 (clamps at both ends, dir flips).
//  T4 TICK_DIV=4, iic_ready held low 20 clk -> pending then overrun=1; stat_clr->0; latest code sent on ready.
//  T5 DATA_W=12, PD_BITS=2'b01, SQR min=12'h000, max=12'hFFF -> wdata alternates 16'h1000/16'h1FFF.
//  T6 drop run during WAIT_LO -> transfer completes, IDLE, no further iic_start.
//     Assert dac_rst_n=0 mid-transfer -> all outputs 0 immediately.

Source files
------------

// File: rtl/dac_wave_gen.sv
// dac_wave_gen: waveform sequencer for an I2C DAC, one 2-byte write per sample tick
// Generates hold/saw/triangle/square codes and reports overrun and ACK errors.
module dac_wave_gen #(
    parameter int          TICK_DIV = 1_000_000,
    parameter int          DATA_W   = 8,
    parameter logic [1:0]  PD_BITS  = 2'b00
) (
    input  logic              dac_clk,
    input  logic              dac_rst_n,
    input  logic              run,
    input  logic [1:0]        cfg_mode,
    input  logic [DATA_W-1:0] cfg_min,
    input  logic [DATA_W-1:0] cfg_max,
    input  logic [DATA_W-1:0] cfg_step,
    input  logic [DATA_W-1:0] cfg_level,
    input  logic              stat_clr,
    input  logic              iic_ready,
    input  logic              iic_ack_error,
    output logic              iic_start,
    output logic [15:0]       iic_wdata,
    output logic [DATA_W-1:0] cur_code,
    output logic              busy,
    output logic              overrun,
    output logic              ack_err
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [1:0] MODE_HOLD = 2'd0;
    localparam logic [1:0] MODE_SAW  = 2'd1;
    localparam logic [1:0] MODE_SQR  = 2'd3;

    typedef enum logic [2:0] {IDLE, WAIT_TICK, LAUNCH, WAIT_LO, WAIT_HI} state_t;

    state_t            state, state_nxt;
    logic              run_q, rise, tick, dir_up, dir_nxt, pending, start_nxt;
    logic [CW-1:0]     tick_cnt;
    logic [DATA_W-1:0] code_nxt, start_code;
    logic [DATA_W:0]   sum, min_step;
    logic [11:0]       code12;

    assign rise       = run && !run_q;
    assign tick       = run && !rise && (tick_cnt == TICK_LAST);
    assign busy       = (state == LAUNCH) || (state == WAIT_LO) || (state == WAIT_HI);
    assign start_code = (cfg_mode == MODE_HOLD) ? cfg_level : cfg_min;
    assign sum        = {1'b0, cur_code} + {1'b0, cfg_step};
    assign min_step   = {1'b0, cfg_min} + {1'b0, cfg_step};
    assign code12     = 12'(cur_code) << (12 - DATA_W);

    // Next waveform code; arithmetic is one bit wider so overflow past max is visible.
    always_comb begin
        code_nxt = cur_code;
        dir_nxt  = dir_up;
        if (cfg_mode == MODE_HOLD)
            code_nxt = cfg_level;
        else if (cfg_min > cfg_max)
            code_nxt = cfg_min;
        else if (cfg_mode == MODE_SAW)
            code_nxt = (sum > {1'b0, cfg_max}) ? cfg_min : sum[DATA_W-1:0];
        else if (cfg_mode == MODE_SQR)
            code_nxt = (cur_code == cfg_min) ? cfg_max : cfg_min;
        else if (dir_up) begin
            code_nxt = (sum >= {1'b0, cfg_max}) ? cfg_max : sum[DATA_W-1:0];
            dir_nxt  = sum < {1'b0, cfg_max};
        end else begin
            code_nxt = ({1'b0, cur_code} < min_step) ? cfg_min : cur_code - cfg_step;
            dir_nxt  = {1'b0, cur_code} < min_step;
        end
    end

    always_ff @(posedge dac_clk or negedge dac_rst_n) begin
        if (!dac_rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_nxt = 1'b0;
        case (state)
            IDLE:      state_nxt = rise ? LAUNCH : IDLE;
            WAIT_TICK: state_nxt = !run ? IDLE : (tick || pending || rise) ? LAUNCH : WAIT_TICK;
            LAUNCH: begin
                start_nxt = iic_ready;
                state_nxt = iic_ready ? WAIT_LO : LAUNCH;
            end
            WAIT_LO:   state_nxt = iic_ready ? WAIT_LO : WAIT_HI;
            WAIT_HI:   state_nxt = !iic_ready ? WAIT_HI : run ? WAIT_TICK : IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // pending marks a code that advanced after the in-flight payload was latched.
    always_ff @(posedge dac_clk or negedge dac_rst_n) begin
        if (!dac_rst_n) begin
            run_q     <= 1'b0;
            tick_cnt  <= '0;
            cur_code  <= '0;
            dir_up    <= 1'b1;
            pending   <= 1'b0;
            overrun   <= 1'b0;
            ack_err   <= 1'b0;
            iic_start <= 1'b0;
            iic_wdata <= '0;
        end else begin
            run_q     <= run;
            iic_start <= start_nxt;
            if (start_nxt)
                iic_wdata <= {2'b00, PD_BITS, code12};
            if (rise) begin
                tick_cnt <= '0;
                cur_code <= start_code;
                dir_up   <= 1'b1;
            end else if (run) begin
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                if (tick) begin
                    cur_code <= code_nxt;
                    dir_up   <= dir_nxt;
                end
            end
            pending <= (busy && (tick || rise)) || (pending && !start_nxt && state != IDLE);
            overrun <= (busy && tick && pending) || (overrun && !stat_clr);
            ack_err <= iic_ack_error || (ack_err && !stat_clr);
        end
    end
endmodule

// File: tb/tb_dac_wave_gen.sv
// tb_dac_wave_gen: scoreboard bench for dac_wave_gen with two parameter sets
// Expected payloads are queued at stimulus time and popped on each iic_start.
module tb_dac_wave_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        a_run, a_ready, a_ackerr, a_clr, a_start, a_busy, a_ovr, a_ack;
    logic [1:0]  a_mode;
    logic [7:0]  a_min, a_max, a_step, a_level, a_code;
    logic [15:0] a_wdata;
    logic        b_run, b_ready, b_ackerr, b_clr, b_start, b_busy, b_ovr, b_ack;
    logic [1:0]  b_mode;
    logic [11:0] b_min, b_max, b_step, b_level, b_code;
    logic [15:0] b_wdata;
    bit          a_stall = 1'b0;

    dac_wave_gen #(.TICK_DIV(8), .DATA_W(8), .PD_BITS(2'b00)) u_a (
        .dac_clk(clk), .dac_rst_n(rst_n), .run(a_run), .cfg_mode(a_mode),
        .cfg_min(a_min), .cfg_max(a_max), .cfg_step(a_step), .cfg_level(a_level),
        .stat_clr(a_clr), .iic_ready(a_ready), .iic_ack_error(a_ackerr),
        .iic_start(a_start), .iic_wdata(a_wdata), .cur_code(a_code),
        .busy(a_busy), .overrun(a_ovr), .ack_err(a_ack));

    dac_wave_gen #(.TICK_DIV(4), .DATA_W(12), .PD_BITS(2'b01)) u_b (
        .dac_clk(clk), .dac_rst_n(rst_n), .run(b_run), .cfg_mode(b_mode),
        .cfg_min(b_min), .cfg_max(b_max), .cfg_step(b_step), .cfg_level(b_level),
        .stat_clr(b_clr), .iic_ready(b_ready), .iic_ack_error(b_ackerr),
        .iic_start(b_start), .iic_wdata(b_wdata), .cur_code(b_code),
        .busy(b_busy), .overrun(b_ovr), .ack_err(b_ack));

    int n_vec = 0;
    int n_bad = 0;
    logic [15:0] qa[$];
    logic [15:0] qb[$];

    typedef struct packed {
        logic [1:0]      mode;
        logic [7:0]      mn, mx, st, lv;
        logic [4:0][7:0] exp;
    } vec_t;
    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] mode, input logic [7:0] mn, mx, st, lv,
                                input logic [7:0] c0, c1, c2, c3, c4);
        vec_t v;
        v.mode = mode; v.mn = mn; v.mx = mx; v.st = st; v.lv = lv;
        v.exp[0] = c0; v.exp[1] = c1; v.exp[2] = c2; v.exp[3] = c3; v.exp[4] = c4;
        return v;
    endfunction

    function automatic logic [15:0] pay8(input logic [7:0] c);
        return {4'h0, c, 4'h0};
    endfunction

    // iic_drive models: ready drops after each start for a fixed number of cycles
    initial begin
        int cnt = 0;
        a_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin cnt = 0; a_ready = 1'b1; end
            else if (a_stall) a_ready = 1'b0;
            else if (cnt > 0) begin cnt--; a_ready = (cnt == 0); end
            else if (a_start) begin a_ready = 1'b0; cnt = 3; end
            else a_ready = 1'b1;
        end
    end

    initial begin
        int cnt = 0;
        b_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin cnt = 0; b_ready = 1'b1; end
            else if (cnt > 0) begin cnt--; b_ready = (cnt == 0); end
            else if (b_start) begin b_ready = 1'b0; cnt = 1; end
            else b_ready = 1'b1;
        end
    end

    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && a_start) begin
                if (qa.size() == 0) chk("a_unexpected_start", a_start, 1'b0);
                else begin e = qa.pop_front(); chk("a_wdata", a_wdata, e); end
            end
        end
    end

    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && b_start) begin
                if (qb.size() == 0) chk("b_unexpected_start", b_start, 1'b0);
                else begin e = qb.pop_front(); chk("b_wdata", b_wdata, e); end
            end
        end
    end

    initial begin
        vt[0] = mk(2'd0, 8'h00, 8'hFF, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5);
        vt[1] = mk(2'd1, 8'h70, 8'h73, 8'h01, 8'h00, 8'h70, 8'h71, 8'h72, 8'h73, 8'h70);
        vt[2] = mk(2'd2, 8'h02, 8'h09, 8'h04, 8'h00, 8'h02, 8'h06, 8'h09, 8'h05, 8'h02);
        vt[3] = mk(2'd3, 8'h10, 8'hF0, 8'h01, 8'h00, 8'h10, 8'hF0, 8'h10, 8'hF0, 8'h10);
        vt[4] = mk(2'd1, 8'h20, 8'h30, 8'h00, 8'h00, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20);
        vt[5] = mk(2'd1, 8'h50, 8'h40, 8'h01, 8'h00, 8'h50, 8'h50, 8'h50, 8'h50, 8'h50);
        vt[6] = mk(2'd2, 8'h00, 8'hFF, 8'h80, 8'h00, 8'h00, 8'h80, 8'hFF, 8'h7F, 8'h00);
        vt[7] = mk(2'd1, 8'hF0, 8'hFF, 8'h08, 8'h00, 8'hF0, 8'hF8, 8'hF0, 8'hF8, 8'hF0);

        rst_n = 1'b0;
        {a_run, a_ackerr, a_clr, a_mode, a_min, a_max, a_step, a_level} = '0;
        {b_run, b_ackerr, b_clr, b_mode, b_min, b_max, b_step, b_level} = '0;
        repeat (3) @(negedge clk);
        chk("a_rst_start", a_start, 0); chk("a_rst_wdata", a_wdata, 0);
        chk("a_rst_code", a_code, 0);   chk("a_rst_busy", a_busy, 0);
        chk("a_rst_ovr", a_ovr, 0);     chk("a_rst_ack", a_ack, 0);
        chk("b_rst_start", b_start, 0); chk("b_rst_wdata", b_wdata, 0);
        chk("b_rst_code", b_code, 0);   chk("b_rst_busy", b_busy, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Five samples per vector: starts two cycles after run rises, then every 8 cycles.
        for (int i = 0; i < 8; i++) begin
            a_mode = vt[i].mode; a_min = vt[i].mn; a_max = vt[i].mx;
            a_step = vt[i].st;   a_level = vt[i].lv;
            for (int k = 0; k < 5; k++) qa.push_back(pay8(vt[i].exp[k]));
            a_run = 1'b1;
            @(negedge clk);
            chk("a_launch_early", a_start, 0);
            @(negedge clk);
            chk("a_launch", a_start, 1);
            chk("a_first_code", a_code, vt[i].exp[0]);
            repeat (34) @(negedge clk);
            a_run = 1'b0;
            repeat (10) @(negedge clk);
            chk("a_vec_idle", a_busy, 0);
            chk("a_vec_queue", qa.size(), 0);
            qa.delete();
        end

        // Stalled bus: ticks pile up into pending then overrun; latest codes go out on ready.
        a_mode = 2'd1; a_min = 8'h00; a_max = 8'hFF; a_step = 8'h01;
        qa.push_back(16'h0020); qa.push_back(16'h0030);
        a_stall = 1'b1; a_run = 1'b1;
        repeat (20) @(negedge clk);
        chk("ovr_set", a_ovr, 1); chk("ovr_busy", a_busy, 1); chk("ovr_code", a_code, 8'h02);
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0; a_stall = 1'b0;
        chk("ovr_clr", a_ovr, 0);
        repeat (8) @(negedge clk);
        a_run = 1'b0;
        repeat (10) @(negedge clk);
        chk("ovr_after", a_ovr, 0); chk("ovr_queue", qa.size(), 0); chk("ovr_idle", a_busy, 0);
        qa.delete();

        // ACK error stickiness and set-over-clear priority
        a_ackerr = 1'b1; @(negedge clk); a_ackerr = 1'b0;
        chk("ack_set", a_ack, 1);
        a_clr = 1'b1; a_ackerr = 1'b1; @(negedge clk); a_clr = 1'b0; a_ackerr = 1'b0;
        chk("ack_set_wins", a_ack, 1);
        a_clr = 1'b1; @(negedge clk); a_clr = 1'b0;
        chk("ack_clr", a_ack, 0);

        // Run dropped during WAIT_LO: transfer completes, no further starts, code held.
        a_mode = 2'd0; a_level = 8'h3C;
        qa.push_back(16'h03C0);
        a_run = 1'b1;
        repeat (2) @(negedge clk);
        a_run = 1'b0;
        chk("drop_busy", a_busy, 1);
        repeat (20) @(negedge clk);
        chk("drop_idle", a_busy, 0); chk("drop_code", a_code, 8'h3C); chk("drop_queue", qa.size(), 0);
        qa.delete();

        // Async reset mid-transfer
        qa.push_back(16'h03C0);
        a_run = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", a_busy, 0); chk("arst_wdata", a_wdata, 0);
        chk("arst_code", a_code, 0); chk("arst_start", a_start, 0);
        a_run = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("arst_quiet", a_start, 0); chk("arst_queue", qa.size(), 0);
        qa.delete();

        // 12-bit, PD=01 square wave, then a hold level
        b_mode = 2'd3; b_min = 12'h000; b_max = 12'hFFF; b_step = 12'h001;
        qb.push_back(16'h1000); qb.push_back(16'h1FFF); qb.push_back(16'h1000); qb.push_back(16'h1FFF);
        b_run = 1'b1;
        repeat (2) @(negedge clk);
        chk("b_launch", b_start, 1);
        repeat (13) @(negedge clk);
        b_run = 1'b0;
        repeat (8) @(negedge clk);
        chk("b_sqr_queue", qb.size(), 0); chk("b_sqr_idle", b_busy, 0);
        qb.delete();
        b_mode = 2'd0; b_level = 12'hABC;
        qb.push_back(16'h1ABC);
        b_run = 1'b1;
        repeat (3) @(negedge clk);
        b_run = 1'b0;
        repeat (8) @(negedge clk);
        chk("b_hold_code", b_code, 12'hABC); chk("b_hold_queue", qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
